matrix_loader_3x3: RTL and testbench
====================================

MATRIX_LOADER_3X3 -- requirements
Module: matrix_loader_3x3

Interface
REQ-001 clk  input  1  sole clock; all state updates on rising edge.
REQ-002 rst_n  input  1  asynchronous, active-low reset.
REQ-003 clear  input  1  synchronous abort of the partial frame and the held matrix.
REQ-004 in_valid  input  1  upstream element valid.
REQ-005 in_ready  output  1  loader can accept an element this cycle.
REQ-006 in_data  input  8  signed two's-complement matrix element, row-major order.
REQ-007 in_last  input  1  marks the 9th element of a frame.
REQ-008 mat_valid  output  1  matriz_3x3 holds a complete matrix.
REQ-009 mat_ready  input  1  downstream (determinant stage) consumes the matrix.
REQ-010 matriz_3x3  output  72  packed signed matrix: element (0,0) in [71:64], (0,1) in [63:56], …, (2,2) in [7:0].
REQ-011 elem_count  output  4  elements accepted into the current partial frame, 0..8.
REQ-012 frame_err  output  1  one-cycle pulse on a framing violation.

Function
REQ-013 The loader SHALL contain a 72-bit assembly buffer, a 4-bit index idx, a 72-bit output register and an out_full flag.
REQ-014 An element SHALL be accepted on a rising edge where in_valid and in_ready are both 1.
REQ-015 in_ready SHALL be 0 only when idx==8 and out_full==1, and SHALL be derived from registered state only, with no combinational path from mat_ready or in_valid.
REQ-016 An accepted element with idx<8 and in_last==0 SHALL be written to assembly bits [71-8*idx : 64-8*idx], and idx SHALL increment.
REQ-017 An accepted element with idx==8 and in_last==1 SHALL load the output register with {assembly[71:8], in_data} at that edge, set out_full, and return idx to 0.
REQ-018 mat_valid SHALL equal out_full; with that edge as edge N, mat_valid SHALL be high in the cycle after edge N (latency 1 from the 9th acceptance).
REQ-019 Framing errors:
- Case 1: in_last==1 accepted with idx<8.
- Case 2: in_last==0 accepted with idx==8.
- In either case the element SHALL be discarded, idx SHALL return to 0, the output register and out_full SHALL be unchanged, and frame_err SHALL pulse for exactly one cycle.
REQ-020 When mat_valid and mat_ready are both 1 at an edge, out_full SHALL clear; matriz_3x3 SHALL retain its value until the next load.
REQ-021 matriz_3x3 SHALL be stable while mat_valid==1, including while the next frame is being assembled.
REQ-022 Simultaneous pop and 9th acceptance cannot occur, because in_ready is 0 whenever idx==8 and out_full==1.
REQ-023 Loading elements 0..7 of the next frame while out_full==1 SHALL be allowed (double buffering).
REQ-024 elem_count SHALL equal idx.
REQ-025 clear==1 SHALL take priority over all other inputs at that edge:
- idx, out_full and frame_err go to 0;
- no element is accepted;
- matriz_3x3 is unchanged.
REQ-026 mat_ready while mat_valid==0 SHALL be ignored.
REQ-027 No arithmetic SHALL be performed on the data; bytes pass bit-exact, sign preserved.

Reset
REQ-028 While rst_n==0, the loader SHALL hold the following values, independent of clk:
- idx=0, out_full=0, mat_valid=0, frame_err=0, elem_count=0;
- matriz_3x3=72'h0 and the assembly buffer=0;
- in_ready=1.
REQ-029 Reset asserted mid-frame or while a matrix is held SHALL discard all data; the first element accepted after deassertion SHALL be treated as element (0,0).

Verification
REQ-030 Frame 1,2,…,9 (in_last on 9) with mat_ready=1 -> matriz_3x3=72'h010203040506070809 and mat_valid high for one cycle after the 9th edge; the downstream determinant=0.
REQ-031 Frame 1,0,2,-1,3,1,3,1,0 -> matriz_3x3=72'h010002FF0301030100; downstream determinant=-21.
REQ-032 Backpressure: mat_ready=0, second frame streamed -> in_ready=0 at elem_count=8, first matrix unchanged; raise mat_ready -> one pop, then the 9th element is accepted and the second matrix appears.
REQ-033 in_last on the 5th element -> frame_err one-cycle pulse, elem_count=0, mat_valid unchanged; no in_last on the 9th element -> same response.
REQ-034 rst_n low after 4 elements -> all outputs at reset values; the next full frame loads correctly from (0,0).
REQ-035 clear asserted with a held matrix and 3 elements pending -> mat_valid=0, elem_count=0, matriz_3x3 unchanged, and in_valid ignored in that cycle.

Source files
------------

// File: rtl/matrix_loader_3x3_if.sv
// rtl/matrix_loader_3x3_if.sv - element stream in, packed 3x3 matrix out, for matrix_loader_3x3
interface matrix_loader_3x3_if;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic        in_last;
    logic        mat_valid;
    logic        mat_ready;
    logic [71:0] matriz_3x3;
    logic [3:0]  elem_count;
    logic        frame_err;

    modport master (
        output in_valid, in_data, in_last, mat_ready,
        input  in_ready, mat_valid, matriz_3x3, elem_count, frame_err
    );

    modport slave (
        input  in_valid, in_data, in_last, mat_ready,
        output in_ready, mat_valid, matriz_3x3, elem_count, frame_err
    );
endinterface

// File: rtl/matrix_loader_3x3.sv
// rtl/matrix_loader_3x3.sv - assembles 9 row-major signed bytes into a double-buffered 3x3 matrix
module matrix_loader_3x3 (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clear,
    matrix_loader_3x3_if.slave bus
);
    logic [71:0] asm_buf;
    logic [71:0] out_reg;
    logic [3:0]  idx;
    logic        out_full;
    logic        err_q;
    logic        accept;
    logic        at_last;

    // The only stall is a completed assembly waiting on a held matrix.
    assign at_last        = (idx == 4'd8);
    assign bus.in_ready   = !(at_last && out_full);
    assign accept         = bus.in_valid && bus.in_ready;

    assign bus.mat_valid  = out_full;
    assign bus.matriz_3x3 = out_reg;
    assign bus.elem_count = idx;
    assign bus.frame_err  = err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            asm_buf  <= '0;
            out_reg  <= '0;
            idx      <= '0;
            out_full <= 1'b0;
            err_q    <= 1'b0;
        end else if (clear) begin
            idx      <= '0;
            out_full <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            err_q <= 1'b0;
            if (out_full && bus.mat_ready) begin
                out_full <= 1'b0;
            end
            if (accept) begin
                if (!at_last) begin
                    if (bus.in_last) begin
                        idx   <= '0;
                        err_q <= 1'b1;
                    end else begin
                        for (int i = 0; i < 8; i++) begin
                            if (idx == 4'(i)) begin
                                asm_buf[71-8*i -: 8] <= bus.in_data;
                            end
                        end
                        idx <= idx + 4'd1;
                    end
                end else begin
                    // Load cannot collide with a pop: in_ready is low here whenever out_full is set.
                    if (bus.in_last) begin
                        out_reg  <= {asm_buf[71:8], bus.in_data};
                        out_full <= 1'b1;
                    end else begin
                        err_q <= 1'b1;
                    end
                    idx <= '0;
                end
            end
        end
    end
endmodule

// File: tb/tb_matrix_loader_3x3.sv
// tb/tb_matrix_loader_3x3.sv - directed scoreboard bench for matrix_loader_3x3
module tb_matrix_loader_3x3;
    logic clk = 1'b0;
    logic rst_n;
    logic clear;

    matrix_loader_3x3_if bus ();

    matrix_loader_3x3 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (clear),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [71:0] sb_q[$];

    task automatic check(input string name, input logic [71:0] got, input logic [71:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", name, got, exp);
        end
    endtask

    function automatic int det3(input logic [71:0] m);
        int a[9];
        logic signed [7:0] t;
        for (int i = 0; i < 9; i++) begin
            t    = m[71-8*i -: 8];
            a[i] = t;
        end
        return a[0]*(a[4]*a[8] - a[5]*a[7])
             - a[1]*(a[3]*a[8] - a[5]*a[6])
             + a[2]*(a[3]*a[7] - a[4]*a[6]);
    endfunction

    // Holds the matrix expected at the output; compared every cycle it is presented.
    always @(negedge clk) begin
        if (rst_n && bus.mat_valid) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL sb_underflow: observed mat_valid=1 expected no matrix pending");
            end else begin
                check("held_matrix", bus.matriz_3x3, sb_q[0]);
                if (bus.mat_ready) void'(sb_q.pop_front());
            end
        end
    end

    task automatic send(input logic [7:0] d, input logic l);
        bit ok = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_last  = l;
        for (int c = 0; c < 50 && !ok; c++) begin
            @(negedge clk);
            ok = bus.in_ready;
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        if (!ok) begin
            checks++;
            errors++;
            $error("FAIL send_timeout: observed in_ready=0 for 50 cycles expected acceptance of %h", d);
        end
    endtask

    task automatic send_frame(input logic [71:0] m, input bit push, input logic last9);
        if (push) sb_q.push_back(m);
        for (int i = 0; i < 9; i++) send(m[71-8*i -: 8], (i == 8) ? last9 : 1'b0);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_in_ready"},   72'(bus.in_ready),   72'd1);
        check({tag, "_mat_valid"},  72'(bus.mat_valid),  72'd0);
        check({tag, "_elem_count"}, 72'(bus.elem_count), 72'd0);
        check({tag, "_frame_err"},  72'(bus.frame_err),  72'd0);
        check({tag, "_matriz"},     bus.matriz_3x3,      72'h0);
    endtask

    localparam logic [71:0] M1 = 72'h010203040506070809;
    localparam logic [71:0] M2 = 72'h010002FF0301030100;
    localparam logic [71:0] MA = 72'h111213141516171819;
    localparam logic [71:0] MB = 72'h2122232425262728A9;
    localparam logic [71:0] MC = 72'h80FF7F0102030405FE;
    localparam logic [71:0] MD = 72'h3132333435363738C9;
    localparam logic [71:0] ME = 72'hF1E2D3C4B5A6978879;
    localparam logic [71:0] MF = 72'h414243444546474849;
    localparam logic [71:0] MG = 72'h5A5B5C5D5E5F606162;

    initial begin
        rst_n         = 1'b0;
        clear         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = 8'h00;
        bus.in_last   = 1'b0;
        bus.mat_ready = 1'b0;
        #3;
        check_reset_vals("reset");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Frame 1..9 with immediate consumption.
        bus.mat_ready = 1'b1;
        send_frame(M1, 1'b1, 1'b1);
        check("f1_mat_valid",  72'(bus.mat_valid),  72'd1);
        check("f1_elem_count", 72'(bus.elem_count), 72'd0);
        check("f1_det",        72'(det3(bus.matriz_3x3)), 72'(0));
        @(posedge clk); #1;
        check("f1_one_cycle",  72'(bus.mat_valid),  72'd0);
        check("f1_retained",   bus.matriz_3x3,      M1);

        send_frame(M2, 1'b1, 1'b1);
        check("f2_matriz", bus.matriz_3x3, M2);
        check("f2_det",    72'(det3(bus.matriz_3x3)), 72'(-21));
        @(posedge clk); #1;

        // Backpressure with a second frame assembling behind a held one.
        bus.mat_ready = 1'b0;
        send_frame(MA, 1'b1, 1'b1);
        for (int i = 0; i < 8; i++) send(MB[71-8*i -: 8], 1'b0);
        check("bp_elem_count", 72'(bus.elem_count), 72'd8);
        check("bp_in_ready",   72'(bus.in_ready),   72'd0);
        check("bp_held",       bus.matriz_3x3,      MA);
        repeat (2) @(posedge clk);
        #1;
        check("bp_still_stalled", 72'(bus.in_ready), 72'd0);
        sb_q.push_back(MB);
        bus.mat_ready = 1'b1;
        send(MB[7:0], 1'b1);
        check("bp_second_valid",  72'(bus.mat_valid), 72'd1);
        check("bp_second_matriz", bus.matriz_3x3,     MB);
        @(posedge clk); #1;

        // Early in_last while a matrix is held.
        bus.mat_ready = 1'b0;
        send_frame(MC, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) send(8'h70 + 8'(i), 1'b0);
        send(8'h74, 1'b1);
        check("ferr1_pulse",      72'(bus.frame_err),  72'd1);
        check("ferr1_elem_count", 72'(bus.elem_count), 72'd0);
        check("ferr1_mat_valid",  72'(bus.mat_valid),  72'd1);
        check("ferr1_matriz",     bus.matriz_3x3,      MC);
        @(posedge clk); #1;
        check("ferr1_one_cycle",  72'(bus.frame_err),  72'd0);

        // Missing in_last on the ninth element.
        bus.mat_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        send_frame(72'h0102030405060708FF, 1'b0, 1'b0);
        check("ferr2_pulse",      72'(bus.frame_err),  72'd1);
        check("ferr2_elem_count", 72'(bus.elem_count), 72'd0);
        check("ferr2_mat_valid",  72'(bus.mat_valid),  72'd0);
        check("ferr2_matriz",     bus.matriz_3x3,      MC);
        @(posedge clk); #1;
        check("ferr2_one_cycle",  72'(bus.frame_err),  72'd0);

        // Reset with a held matrix and a partial frame.
        bus.mat_ready = 1'b0;
        send_frame(MD, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) send(8'hE0 + 8'(i), 1'b0);
        rst_n = 1'b0;
        #2;
        check_reset_vals("midreset");
        sb_q.delete();
        @(posedge clk);
        #1 rst_n = 1'b1;
        bus.mat_ready = 1'b1;
        send_frame(ME, 1'b1, 1'b1);
        check("post_reset_valid",  72'(bus.mat_valid), 72'd1);
        check("post_reset_matriz", bus.matriz_3x3,     ME);
        @(posedge clk); #1;

        // Clear with a held matrix, three pending elements and a competing element.
        bus.mat_ready = 1'b0;
        send_frame(MF, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) send(8'hD0 + 8'(i), 1'b0);
        clear        = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h77;
        @(posedge clk);
        #1;
        clear        = 1'b0;
        bus.in_valid = 1'b0;
        check("clear_mat_valid",  72'(bus.mat_valid),  72'd0);
        check("clear_elem_count", 72'(bus.elem_count), 72'd0);
        check("clear_matriz",     bus.matriz_3x3,      MF);
        check("clear_frame_err",  72'(bus.frame_err),  72'd0);
        sb_q.delete();
        bus.mat_ready = 1'b1;
        send_frame(MG, 1'b1, 1'b1);
        check("post_clear_matriz", bus.matriz_3x3, MG);

        repeat (3) @(posedge clk);
        #1;
        check("sb_drained", 72'(sb_q.size()), 72'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
